// File: rtl/xor_cipher_pkg.sv
// ---------------------------------------------------------------------------
// xor_cipher_pkg
// Shared definitions for the xor_cipher_ctrl block:
//   - state_t       : controller state encoding (IDLE / RUN / DONE)
//   - DEF_NIBBLES   : default number of 4-bit nibbles per data word
//   - DEF_KEY_W     : default key register width in bits
// ---------------------------------------------------------------------------
package xor_cipher_pkg;

    localparam int DEF_NIBBLES = 4;
    localparam int DEF_KEY_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : xor_cipher_pkg

// File: rtl/mux2to1_4bit.sv
// ---------------------------------------------------------------------------
// mux2to1_4bit
// Purely combinational 4-bit two-way select.
// Ports:
//   in1 [3:0] : selected when key = 0
//   in2 [3:0] : selected when key = 1
//   key       : select bit
//   out [3:0] : selected nibble
// ---------------------------------------------------------------------------
module mux2to1_4bit (
    input  logic [3:0] in1,
    input  logic [3:0] in2,
    input  logic       key,
    output logic [3:0] out
);

    assign out = key ? in2 : in1;

endmodule : mux2to1_4bit

// File: rtl/xor_cipher_ctrl.sv
// ---------------------------------------------------------------------------
// xor_cipher_ctrl
// Nibble-serial XOR-style cipher. An accepted word is processed one nibble
// per cycle, LSB nibble first; each nibble is inverted when the current key
// bit key[ptr] is 1 and passed through otherwise. The key pointer advances
// once per nibble and wraps at KEY_W-1, forming a continuous key stream
// across words.
//
// Build option:
//   XOR_CIPHER_KEY_RESTART_EN : when defined, the key pointer restarts at 0
//                               on every input accept, so each word uses key
//                               bits from 0 upward.
//
// Parameters:
//   NIBBLES : nibbles per word (word width W = 4*NIBBLES)
//   KEY_W   : key register width in bits
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   key_load  : load strobe for key_in (honoured in IDLE only)
//   key_in    : new key value
//   in_valid  : input word valid
//   in_ready  : block accepts an input word (IDLE only)
//   in_data   : input word
//   out_valid : result valid (DONE only)
//   out_ready : downstream accepts the result
//   out_data  : result word, held while out_valid & !out_ready
//   busy      : high whenever the controller is not IDLE
// ---------------------------------------------------------------------------
module xor_cipher_ctrl
    import xor_cipher_pkg::*;
#(
    parameter int NIBBLES = DEF_NIBBLES,
    parameter int KEY_W   = DEF_KEY_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   key_load,
    input  logic [KEY_W-1:0]       key_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   out_data,
    output logic                   busy
);

    localparam int W     = 4 * NIBBLES;
    localparam int CNT_W = $clog2(NIBBLES + 1);
    localparam int PTR_W = (KEY_W > 1) ? $clog2(KEY_W) : 1;

    // cnt_q reaching NIBBLES means every nibble has been transformed; that
    // extra RUN cycle publishes the finished word into out_data.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(KEY_W - 1);

    state_t            state_q, state_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [W-1:0]      data_q, data_d;
    logic [W-1:0]      out_data_q, out_data_d;

    logic [3:0]        nib_in [NIBBLES];
    logic [3:0]        nib_cur;
    logic [3:0]        nib_out;
    logic              key_bit;
    logic [W-1:0]      data_upd;

    // The word is transformed in place: the nibble at position cnt_q is
    // replaced by its ciphered value, all others are kept.
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
        assign nib_in[gi]             = data_q[gi*4 +: 4];
        assign data_upd[gi*4 +: 4]    = (cnt_q == CNT_W'(gi)) ? nib_out : nib_in[gi];
    end

    always_comb begin
        nib_cur = 4'h0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                nib_cur = nib_in[i];
            end
        end
    end

    assign key_bit = key_q[ptr_q];

    mux2to1_4bit u_nib_mux (
        .in1 (nib_cur),
        .in2 (~nib_cur),
        .key (key_bit),
        .out (nib_out)
    );

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        out_data_d = out_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (key_load) begin
                    key_d = key_in;
                    ptr_d = '0;
                end
                if (in_valid) begin
                    data_d  = in_data;
                    cnt_d   = '0;
                    state_d = ST_RUN;
`ifdef XOR_CIPHER_KEY_RESTART_EN
                    ptr_d   = '0;
`endif
                end
            end
            ST_RUN: begin
                if (cnt_q == CNT_LAST) begin
                    out_data_d = data_q;
                    state_d    = ST_DONE;
                end else begin
                    data_d = data_upd;
                    cnt_d  = cnt_q + CNT_W'(1);
                    ptr_d  = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            key_q      <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            data_q     <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            out_data_q <= out_data_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out_data  = out_data_q;

endmodule : xor_cipher_ctrl
